// File: rtl/pipe_field_renderer.sv
// pipe_field_renderer: NUM_PIPES double-buffered pipe descriptors hit-tested per pixel; PIPE_COLLISION_EN adds a sticky bird collision flag.
// Latency: fixed 2 cycles from pix_valid to out_valid, one pixel per cycle.
// Backpressure: none; the pipeline never stalls and pix_valid may drop on any cycle.

// Image ROM with 1-cycle synchronous read; colour word is derived from the address.
module pipe_image_rom #(
  parameter int            AW   = 16,
  parameter int            DW   = 12,
  parameter logic [DW-1:0] TINT = '0
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] data
);
  always_ff @(posedge clk)
    data <= DW'(addr) ^ DW'(addr >> DW) ^ TINT;
endmodule

module pipe_field_renderer #(
  parameter int SCREEN_WIDTH    = 640,
  parameter int SCREEN_HEIGHT   = 480,
  parameter int NUM_PIPES       = 4,
  parameter int PIPE_WIDTH      = 70,
  parameter int PIPE_CAP_HEIGHT = 10,
  parameter int BITS_PER_COLOR  = 12,
  parameter int IDX_W           = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [IDX_W-1:0]          wr_idx,
  input  logic [31:0]               wr_left_edge,
  input  logic [31:0]               wr_bottom_top,
  input  logic [31:0]               wr_gap_height,
  input  logic                      frame_start,
  input  logic                      pix_valid,
  input  logic [9:0]                x,
  input  logic [8:0]                y,
`ifdef PIPE_COLLISION_EN
  input  logic                      bird_pixel,
  input  logic                      collision_clr,
  output logic                      collision,
`endif
  output logic                      out_valid,
  output logic                      inside_pipe,
  output logic [IDX_W-1:0]          pipe_idx,
  output logic [BITS_PER_COLOR-1:0] colorData
);
  localparam int SH_AW  = $clog2(PIPE_WIDTH * SCREEN_HEIGHT);
  localparam int CAP_AW = $clog2(PIPE_WIDTH * PIPE_CAP_HEIGHT);

  logic [31:0] sh_left   [NUM_PIPES];
  logic [31:0] sh_bottom [NUM_PIPES];
  logic [31:0] sh_gap    [NUM_PIPES];
  logic [31:0] act_left  [NUM_PIPES];
  logic [31:0] act_bottom[NUM_PIPES];
  logic [31:0] act_gap   [NUM_PIPES];

  // Active copy is taken from the pre-write shadow when wr_en and frame_start coincide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        sh_left[i]    <= '0;
        sh_bottom[i]  <= '0;
        sh_gap[i]     <= '0;
        act_left[i]   <= '0;
        act_bottom[i] <= '0;
        act_gap[i]    <= '0;
      end
    end else begin
      if (frame_start) begin
        for (int i = 0; i < NUM_PIPES; i++) begin
          act_left[i]   <= sh_left[i];
          act_bottom[i] <= sh_bottom[i];
          act_gap[i]    <= sh_gap[i];
        end
      end
      if (wr_en && (32'(wr_idx) < NUM_PIPES)) begin
        sh_left[wr_idx]   <= wr_left_edge;
        sh_bottom[wr_idx] <= wr_bottom_top;
        sh_gap[wr_idx]    <= wr_gap_height;
      end
    end
  end

  logic signed [31:0] xs, ys;
  logic               vis;
  assign xs  = $signed({22'd0, x});
  assign ys  = $signed({23'd0, y});
  assign vis = (xs < SCREEN_WIDTH) && (ys < SCREEN_HEIGHT);

  logic [NUM_PIPES-1:0]            slot_hit;
  logic [NUM_PIPES-1:0]            slot_cap;
  logic [NUM_PIPES-1:0][SH_AW-1:0] slot_addr;

  for (genvar g = 0; g < NUM_PIPES; g++) begin : g_slot
    logic signed [31:0] bt, gt, col;
    logic act, in_x, top_cap, top_sh, bot_cap, bot_sh;

    assign bt      = $signed(act_bottom[g]);
    assign gt      = bt - $signed(act_gap[g]);
    assign col     = xs - $signed(act_left[g]);
    assign act     = (act_bottom[g] != '0) && (act_gap[g] != '0);
    assign in_x    = (col >= 0) && (col < PIPE_WIDTH);
    assign top_cap = (ys >= gt - PIPE_CAP_HEIGHT) && (ys < gt);
    assign top_sh  = ys < gt - PIPE_CAP_HEIGHT;
    assign bot_cap = (ys >= bt) && (ys < bt + PIPE_CAP_HEIGHT);
    assign bot_sh  = ys >= bt + PIPE_CAP_HEIGHT;

    assign slot_hit[g] = act && in_x && vis && (top_cap || top_sh || bot_cap || bot_sh);
    assign slot_cap[g] = top_cap || bot_cap;
    // Top cap rows are read bottom-up so the lip faces the gap.
    assign slot_addr[g] = top_cap ? SH_AW'(col + PIPE_WIDTH * (gt - 32'sd1 - ys)) :
                          bot_cap ? SH_AW'(col + PIPE_WIDTH * (ys - bt)) :
                          top_sh  ? SH_AW'(col + PIPE_WIDTH * ys) :
                                    SH_AW'(col + PIPE_WIDTH * (ys - bt - PIPE_CAP_HEIGHT));
  end

  logic [IDX_W-1:0] win_idx;
  logic             win_cap;
  logic [SH_AW-1:0] win_addr;

  always_comb begin
    win_idx  = '0;
    win_cap  = 1'b0;
    win_addr = '0;
    for (int i = NUM_PIPES - 1; i >= 0; i--) begin
      if (slot_hit[i]) begin
        win_idx  = IDX_W'(i);
        win_cap  = slot_cap[i];
        win_addr = slot_addr[i];
      end
    end
  end

  logic                 v1, cap1, out_v, inside_q, cap2;
  logic [NUM_PIPES-1:0] hit_vec1;
  logic [IDX_W-1:0]     idx1, idx_q;
  logic [SH_AW-1:0]     addr1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1       <= 1'b0;
      hit_vec1 <= '0;
      idx1     <= '0;
      cap1     <= 1'b0;
      addr1    <= '0;
      out_v    <= 1'b0;
      inside_q <= 1'b0;
      idx_q    <= '0;
      cap2     <= 1'b0;
    end else begin
      v1       <= pix_valid;
      hit_vec1 <= pix_valid ? slot_hit : '0;
      idx1     <= win_idx;
      cap1     <= win_cap;
      addr1    <= win_addr;
      out_v    <= v1;
      inside_q <= v1 && (|hit_vec1);
      idx_q    <= (v1 && (|hit_vec1)) ? idx1 : '0;
      cap2     <= cap1;
    end
  end

  logic [BITS_PER_COLOR-1:0] shaft_dat, cap_dat;

  pipe_image_rom #(.AW(SH_AW), .DW(BITS_PER_COLOR), .TINT('0)) u_shaft_rom (
    .clk  (clk),
    .addr (addr1),
    .data (shaft_dat)
  );

  pipe_image_rom #(.AW(CAP_AW), .DW(BITS_PER_COLOR), .TINT('1)) u_cap_rom (
    .clk  (clk),
    .addr (CAP_AW'(addr1)),
    .data (cap_dat)
  );

  assign out_valid   = out_v;
  assign inside_pipe = inside_q;
  assign pipe_idx    = idx_q;
  assign colorData   = !inside_q ? '0 : (cap2 ? cap_dat : shaft_dat);

`ifdef PIPE_COLLISION_EN
  logic bird1;

  // A new hit beats a clear arriving on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bird1     <= 1'b0;
      collision <= 1'b0;
    end else begin
      bird1 <= pix_valid && bird_pixel;
      if (v1 && bird1 && (|hit_vec1))
        collision <= 1'b1;
      else if (collision_clr)
        collision <= 1'b0;
    end
  end
`endif
endmodule
